// File: rtl/iq_avg_scheduler_pkg.sv
// Shared definitions for the I/Q averaging scheduler: FSM encoding and default widths.
package iq_avg_scheduler_pkg;

    localparam int DEFAULT_NBITS = 16;
    localparam int DEFAULT_DIV_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/iq_result_buffer.sv
// Single-entry {I,Q} result holding register with valid/ready output, sticky drop flag
// and a wrapping count of captured results.
module iq_result_buffer #(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture,
    input  logic [W-1:0]  in_data,
    input  logic          m_ready,
    output logic          m_valid,
    output logic [W-1:0]  m_data,
    output logic          overrun,
    output logic [15:0]   window_count
);

    // A transfer on m_valid && m_ready frees the slot in the same cycle,
    // so a new result can land while the old one is being taken.
    logic accept;
    assign accept = capture && (!m_valid || m_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid      <= 1'b0;
            m_data       <= '0;
            overrun      <= 1'b0;
            window_count <= 16'd0;
        end else begin
            if (accept) begin
                m_valid      <= 1'b1;
                m_data       <= in_data;
                window_count <= window_count + 16'd1;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
            if (capture && m_valid && !m_ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/iq_avg_scheduler.sv
// Sequences the I/Q averagers: arms on enable, starts on a second marker, generates
// carrier-period strobes and window-close markers, and buffers averaged results.
module iq_avg_scheduler
    import iq_avg_scheduler_pkg::*;
#(
    parameter int NBITS = DEFAULT_NBITS,
    parameter int DIV_W = DEFAULT_DIV_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [DIV_W-1:0]        carrier_div,
    input  logic                    sec_sync,
    input  logic                    sample_strobe,
    output logic                    msf_carrier_pulse,
    output logic                    one_sec_marker,
    output logic                    load_val,
    input  logic signed [NBITS-1:0] i_average,
    input  logic signed [NBITS-1:0] q_average,
    input  logic                    avg_valid,
    output logic [2*NBITS-1:0]      m_data,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    overrun,
    output logic [15:0]             window_count,
    output logic [1:0]              dbg_state
);

    state_t           state;
    logic             sec_prev;
    logic             sec_edge;
    logic             run;
    logic [DIV_W-1:0] div_cnt;
    logic             pending;

    assign sec_edge  = sec_sync && !sec_prev;
    assign run       = (state == ST_RUN);
    assign dbg_state = state;

    // Strobes are decoded from registered state; rst gates them so nothing fires in the reset cycle.
    assign msf_carrier_pulse = run && !rst && (div_cnt == carrier_div);
    assign one_sec_marker    = msf_carrier_pulse && (pending || sec_edge);
    assign load_val          = run && !rst && sample_strobe;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            sec_prev <= 1'b0;
            div_cnt  <= '0;
            pending  <= 1'b0;
        end else begin
            sec_prev <= sec_sync;

            if (!enable) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_ARM;
                    ST_ARM:  if (sec_edge) state <= ST_RUN;
                    ST_RUN:  state <= ST_RUN;
                    default: state <= ST_IDLE;
                endcase
            end

            if (!run) begin
                div_cnt <= '0;
            end else if (div_cnt == carrier_div) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            // An edge on a pulse cycle is consumed by that pulse's marker.
            if (!run || msf_carrier_pulse) begin
                pending <= 1'b0;
            end else if (sec_edge) begin
                pending <= 1'b1;
            end
        end
    end

    iq_result_buffer #(
        .W (2*NBITS)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .capture      (avg_valid && run),
        .in_data      ({i_average, q_average}),
        .m_ready      (m_ready),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .overrun      (overrun),
        .window_count (window_count)
    );

endmodule

// File: tb/tb_iq_avg_scheduler.sv
// Directed bench for iq_avg_scheduler: sequencing, carrier/marker timing and result buffering.
module tb_iq_avg_scheduler;
    import iq_avg_scheduler_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic [15:0]        carrier_div = 16'd0;
    logic               sec_sync = 1'b0;
    logic               sample_strobe = 1'b0;
    logic               msf_carrier_pulse;
    logic               one_sec_marker;
    logic               load_val;
    logic signed [15:0] i_average = 16'sd0;
    logic signed [15:0] q_average = 16'sd0;
    logic               avg_valid = 1'b0;
    logic [31:0]        m_data;
    logic               m_valid;
    logic               m_ready = 1'b0;
    logic               overrun;
    logic [15:0]        window_count;
    logic [1:0]         dbg_state;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    iq_avg_scheduler dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .carrier_div       (carrier_div),
        .sec_sync          (sec_sync),
        .sample_strobe     (sample_strobe),
        .msf_carrier_pulse (msf_carrier_pulse),
        .one_sec_marker    (one_sec_marker),
        .load_val          (load_val),
        .i_average         (i_average),
        .q_average         (q_average),
        .avg_valid         (avg_valid),
        .m_data            (m_data),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .overrun           (overrun),
        .window_count      (window_count),
        .dbg_state         (dbg_state)
    );

    // Advance one clock; inputs set after this apply at the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++; if (m_data !== 32'h0) begin failures++; $display("FAIL reset_m_data got=%h exp=00000000", m_data); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
        checks++; if (window_count !== 16'd0) begin failures++; $display("FAIL reset_window_count got=%0d exp=0", window_count); end
        checks++; if (msf_carrier_pulse !== 1'b0 || one_sec_marker !== 1'b0) begin failures++; $display("FAIL reset_strobes got=%b%b exp=00", msf_carrier_pulse, one_sec_marker); end
    endtask

    task automatic test_carrier();
        carrier_div = 16'd9;
        enable = 1'b1;
        cyc();
        checks++; if (dbg_state !== ST_ARM) begin failures++; $display("FAIL arm_state got=%0d exp=%0d", dbg_state, ST_ARM); end
        cyc();
        checks++; if (dbg_state !== ST_ARM || msf_carrier_pulse !== 1'b0) begin failures++; $display("FAIL arm_hold got=%0d/%b exp=%0d/0", dbg_state, msf_carrier_pulse, ST_ARM); end
        sec_sync = 1'b1;
        cyc();
        sec_sync = 1'b0;
        checks++; if (dbg_state !== ST_RUN) begin failures++; $display("FAIL run_entry got=%0d exp=%0d", dbg_state, ST_RUN); end
        for (int k = 0; k < 30; k++) begin
            #1;
            checks++; if (msf_carrier_pulse !== ((k % 10) == 9)) begin failures++; $display("FAIL carrier_pulse k=%0d got=%b exp=%b", k, msf_carrier_pulse, (k % 10) == 9); end
            checks++; if (one_sec_marker !== 1'b0) begin failures++; $display("FAIL arm_edge_marker k=%0d got=%b exp=0", k, one_sec_marker); end
            cyc();
        end
    endtask

    task automatic test_marker();
        // Divider is at count 0 here; edges at count 3 of period 0 and on the pulse of period 2.
        for (int k = 0; k < 40; k++) begin
            sec_sync = (k == 3) || (k == 29);
            #1;
            checks++; if (msf_carrier_pulse !== ((k % 10) == 9)) begin failures++; $display("FAIL marker_pulse k=%0d got=%b exp=%b", k, msf_carrier_pulse, (k % 10) == 9); end
            checks++; if (one_sec_marker !== ((k == 9) || (k == 29))) begin failures++; $display("FAIL one_sec_marker k=%0d got=%b exp=%b", k, one_sec_marker, (k == 9) || (k == 29)); end
            cyc();
        end
        sec_sync = 1'b0;
        sample_strobe = 1'b1;
        #1;
        checks++; if (load_val !== 1'b1) begin failures++; $display("FAIL load_val_run got=%b exp=1", load_val); end
        sample_strobe = 1'b0;
        #1;
        checks++; if (load_val !== 1'b0) begin failures++; $display("FAIL load_val_nostrobe got=%b exp=0", load_val); end
    endtask

    task automatic test_capture();
        m_ready = 1'b1;
        i_average = 16'sh1234;
        q_average = 16'shFEDC;
        avg_valid = 1'b1;
        cyc();
        avg_valid = 1'b0;
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL capture_valid got=%b exp=1", m_valid); end
        checks++; if (m_data !== 32'h1234FEDC) begin failures++; $display("FAIL capture_data got=%h exp=1234fedc", m_data); end
        checks++; if (window_count !== 16'd1) begin failures++; $display("FAIL capture_count got=%0d exp=1", window_count); end
        cyc();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL capture_drain got=%b exp=0", m_valid); end
    endtask

    task automatic test_overrun();
        m_ready = 1'b0;
        i_average = 16'sh0001;
        q_average = 16'sh0002;
        avg_valid = 1'b1;
        cyc();
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_early got=%b exp=0", overrun); end
        i_average = 16'sh0003;
        q_average = 16'sh0004;
        cyc();
        avg_valid = 1'b0;
        checks++; if (m_data !== 32'h00010002) begin failures++; $display("FAIL overrun_held got=%h exp=00010002", m_data); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_set got=%b exp=1", overrun); end
        checks++; if (window_count !== 16'd2) begin failures++; $display("FAIL overrun_count got=%0d exp=2", window_count); end
        cyc();
        cyc();
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h00010002) begin failures++; $display("FAIL stall_stable got=%b/%h exp=1/00010002", m_valid, m_data); end
    endtask

    task automatic test_disable();
        enable = 1'b0;
        sample_strobe = 1'b1;
        cyc();
        checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL disable_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        checks++; if (load_val !== 1'b0 || msf_carrier_pulse !== 1'b0 || one_sec_marker !== 1'b0) begin failures++; $display("FAIL disable_strobes got=%b%b%b exp=000", load_val, msf_carrier_pulse, one_sec_marker); end
        sample_strobe = 1'b0;
        i_average = 16'sh7777;
        q_average = 16'sh8888;
        avg_valid = 1'b1;
        cyc();
        checks++; if (m_data !== 32'h00010002 || window_count !== 16'd2) begin failures++; $display("FAIL idle_ignore got=%h/%0d exp=00010002/2", m_data, window_count); end
        avg_valid = 1'b0;
        m_ready = 1'b1;
        #1;
        checks++; if (m_valid !== 1'b1 || m_data !== 32'h00010002) begin failures++; $display("FAIL idle_deliver got=%b/%h exp=1/00010002", m_valid, m_data); end
        cyc();
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL idle_drained got=%b exp=0", m_valid); end
        avg_valid = 1'b1;
        cyc();
        avg_valid = 1'b0;
        checks++; if (m_valid !== 1'b0 || window_count !== 16'd2) begin failures++; $display("FAIL idle_empty_ignore got=%b/%0d exp=0/2", m_valid, window_count); end
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_sticky got=%b exp=1", overrun); end
    endtask

    task automatic test_div_zero();
        carrier_div = 16'd0;
        enable = 1'b1;
        cyc();
        sec_sync = 1'b1;
        cyc();
        sec_sync = 1'b0;
        checks++; if (dbg_state !== ST_RUN) begin failures++; $display("FAIL div0_run got=%0d exp=%0d", dbg_state, ST_RUN); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (msf_carrier_pulse !== 1'b1) begin failures++; $display("FAIL div0_pulse k=%0d got=%b exp=1", k, msf_carrier_pulse); end
            cyc();
        end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        i_average = 16'sh0ABC;
        q_average = 16'sh0DEF;
        avg_valid = 1'b1;
        cyc();
        avg_valid = 1'b0;
        checks++; if (m_valid !== 1'b1 || window_count !== 16'd3) begin failures++; $display("FAIL pre_reset got=%b/%0d exp=1/3", m_valid, window_count); end
        rst = 1'b1;
        #1;
        checks++; if (msf_carrier_pulse !== 1'b0) begin failures++; $display("FAIL reset_cycle_pulse got=%b exp=0", msf_carrier_pulse); end
        cyc();
        rst = 1'b0;
        checks++; if (m_valid !== 1'b0 || overrun !== 1'b0 || window_count !== 16'd0) begin failures++; $display("FAIL mid_reset got=%b/%b/%0d exp=0/0/0", m_valid, overrun, window_count); end
        checks++; if (dbg_state !== ST_IDLE || m_data !== 32'h0) begin failures++; $display("FAIL mid_reset_state got=%0d/%h exp=%0d/00000000", dbg_state, m_data, ST_IDLE); end
    endtask

    initial begin
        test_reset();
        test_carrier();
        test_marker();
        test_capture();
        test_overrun();
        test_disable();
        test_div_zero();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
